// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle data-memory access controller and MEM/WB pipeline register
// Ports:
//   clk, rst (async, active-low)
//   wb_en, mem_read, mem_write, alu_res, val_rm, dest : EXE/MEM fields
//   mem_addr, mem_wdata, mem_re, mem_we, mem_rdata   : data-memory array port
//   freeze                                           : upstream pipeline stall
//   wb_wb_en, wb_mem_r_en, wb_alu_res, wb_mem_data, wb_dest : MEM/WB fields
//   addr_err                                         : one-cycle out-of-range pulse
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH       = 64,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_en,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [31:0]   alu_res,
    input  logic [31:0]   val_rm,
    input  logic [3:0]    dest,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata,
    output logic          freeze,
    output logic          wb_wb_en,
    output logic          wb_mem_r_en,
    output logic [31:0]   wb_alu_res,
    output logic [31:0]   wb_mem_data,
    output logic [3:0]    wb_dest,
    output logic          addr_err
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] l_idx;
    logic [31:0]   l_alu, l_rm;
    logic [3:0]    l_dest;
    logic          l_wb_en, l_wr, l_oor;
    logic          req, oor;
    logic [29:0]   idx;
    assign req = mem_read | mem_write;
    assign idx = 30'((alu_res - 32'(BASE_ADDR)) >> 2);
    assign oor = (alu_res < 32'(BASE_ADDR)) || (idx >= 30'(DEPTH));
    assign mem_addr  = l_idx;
    assign mem_wdata = l_rm;
    // Strobes and stall decode only registered state, never mem_rdata
    always_comb begin
        mem_re = (state == ACCESS) && !l_wr && !l_oor;
        mem_we = (state == ACCESS) && (cnt == 4'd0) && l_wr && !l_oor;
        freeze = (state == IDLE) ? req : (cnt != 4'd0);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            l_idx       <= '0;
            l_alu       <= 32'd0;
            l_rm        <= 32'd0;
            l_dest      <= 4'd0;
            l_wb_en     <= 1'b0;
            l_wr        <= 1'b0;
            l_oor       <= 1'b0;
            wb_wb_en    <= 1'b0;
            wb_mem_r_en <= 1'b0;
            wb_alu_res  <= 32'd0;
            wb_mem_data <= 32'd0;
            wb_dest     <= 4'd0;
            addr_err    <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (state == IDLE) begin
                wb_mem_r_en <= 1'b0;
                if (req) begin
                    wb_wb_en <= 1'b0;
                    l_idx    <= idx[AW-1:0];
                    l_alu    <= alu_res;
                    l_rm     <= val_rm;
                    l_dest   <= dest;
                    l_wb_en  <= wb_en;
                    l_wr     <= mem_write;
                    l_oor    <= oor;
                    cnt      <= 4'(WAIT_CYCLES - 1);
                    state    <= ACCESS;
                end else begin
                    wb_wb_en   <= wb_en;
                    wb_alu_res <= alu_res;
                    wb_dest    <= dest;
                end
            end else if (cnt != 4'd0) begin
                wb_wb_en    <= 1'b0;
                wb_mem_r_en <= 1'b0;
                cnt         <= cnt - 4'd1;
            end else begin
                wb_wb_en    <= l_wb_en;
                wb_mem_r_en <= !l_wr;
                wb_alu_res  <= l_alu;
                wb_dest     <= l_dest;
                // writes and out-of-range reads return zero
                wb_mem_data <= (l_wr || l_oor) ? 32'd0 : mem_rdata;
                addr_err    <= l_oor;
                state       <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;
    localparam int W = 3, BASE = 1024, DEPTH = 64, AW = 6;

    logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
    always #5 clk = ~clk;

    logic          wb_en, mem_read, mem_write;
    logic [31:0]   alu_res, val_rm;
    logic [3:0]    dest;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata, wb_alu_res, wb_mem_data;
    logic          mem_re, mem_we, freeze, wb_wb_en, wb_mem_r_en, addr_err;
    logic [3:0]    wb_dest;

    logic          wb_en1, rd1, wr1;
    logic [31:0]   alu1, rm1;
    logic [3:0]    dest1;
    logic [AW-1:0] mem_addr1;
    logic [31:0]   mem_wdata1, mem_rdata1, wb_alu_res1, wb_mem_data1;
    logic          mem_re1, mem_we1, freeze1, wb_wb_en1, wb_mem_r_en1, addr_err1;
    logic [3:0]    wb_dest1;

    mem_access_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .mem_read(mem_read), .mem_write(mem_write),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .freeze(freeze), .wb_wb_en(wb_wb_en), .wb_mem_r_en(wb_mem_r_en),
        .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data), .wb_dest(wb_dest),
        .addr_err(addr_err));

    mem_access_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .wb_en(wb_en1), .mem_read(rd1), .mem_write(wr1),
        .alu_res(alu1), .val_rm(rm1), .dest(dest1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_re(mem_re1), .mem_we(mem_we1), .mem_rdata(mem_rdata1),
        .freeze(freeze1), .wb_wb_en(wb_wb_en1), .wb_mem_r_en(wb_mem_r_en1),
        .wb_alu_res(wb_alu_res1), .wb_mem_data(wb_mem_data1), .wb_dest(wb_dest1),
        .addr_err(addr_err1));

    logic [31:0] init_val [DEPTH];
    logic [31:0] arr [DEPTH];
    logic [31:0] arr1 [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    assign mem_rdata  = arr[mem_addr];
    assign mem_rdata1 = arr1[mem_addr1];
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < DEPTH; i++) arr[i] <= init_val[i];
        else if (mem_we) arr[mem_addr] <= mem_wdata;
    end
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < DEPTH; i++) arr1[i] <= init_val[i];
        else if (mem_we1) arr1[mem_addr1] <= mem_wdata1;
    end

    int checks = 0, fails = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        wbe, re, ae, mdc;
        logic [3:0]  dst;
        logic [31:0] alu, md;
    } exp_t;
    exp_t q[$];
    logic [31:0] last_md = 32'd0;
    logic        md_known = 1'b1;

    logic mon_en = 1'b0, armed = 1'b0, prev_f = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (!mon_en) armed = 1'b0;
        else if (!armed) armed = 1'b1;
        else if (prev_f) chk("bubble", {wb_wb_en, wb_mem_r_en, addr_err}, 3'b000);
        else if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
            e = q.pop_front();
            chk("wb_fields", {wb_wb_en, wb_mem_r_en, addr_err, wb_dest, wb_alu_res},
                {e.wbe, e.re, e.ae, e.dst, e.alu});
            if (e.mdc) chk("wb_mem_data", wb_mem_data, e.md);
        end
        prev_f = freeze;
    end

    task automatic issue(input logic rd, input logic wr, input logic we_,
                         input logic [31:0] a, input logic [31:0] rm, input logic [3:0] d);
        exp_t e;
        logic [31:0] off;
        logic [AW-1:0] ix, wa;
        logic [31:0] wd;
        logic oor, req;
        int nf, rc, wc, cyc;
        off = a - 32'(BASE);
        oor = (a < 32'(BASE)) || ((off >> 2) >= 32'(DEPTH));
        ix  = off[AW+1:2];
        req = rd | wr;
        @(negedge clk);
        wb_en = we_; mem_read = rd; mem_write = wr; alu_res = a; val_rm = rm; dest = d;
        e.wbe = we_; e.alu = a; e.dst = d; e.ae = req && oor; e.re = rd && !wr;
        if (!req) begin
            e.md = last_md; e.mdc = md_known;
        end else if (wr) begin
            e.md = 32'd0; e.mdc = rd; last_md = 32'd0; md_known = rd;
        end else begin
            e.md = oor ? 32'd0 : ref_mem[ix]; e.mdc = 1'b1; last_md = e.md; md_known = 1'b1;
        end
        if (wr && !oor) ref_mem[ix] = rm;
        q.push_back(e);
        nf = 0; rc = 0; wc = 0; cyc = 0; wa = '0; wd = 32'd0;
        forever begin
            #3;
            nf += int'(freeze);
            rc += int'(mem_re);
            if (mem_we) begin wc++; wa = mem_addr; wd = mem_wdata; end
            if (!freeze) break;
            if (++cyc > 40) begin chk("op_timeout", 1, 0); break; end
            @(negedge clk);
        end
        chk("freeze_cycles", nf, req ? W : 0);
        chk("re_cycles", rc, (rd && !wr && !oor) ? W : 0);
        chk("we_pulses", wc, (wr && !oor) ? 1 : 0);
        if (wr && !oor) chk("we_addr_data", {wa, wd}, {ix, rm});
    endtask

    task automatic idle_in();
        wb_en = 0; mem_read = 0; mem_write = 0; alu_res = 0; val_rm = 0; dest = 0;
    endtask

    task automatic mon_on();
        @(negedge clk); #4; mon_en = 1'b1;
    endtask

    task automatic mon_off();
        @(negedge clk); idle_in(); #4; mon_en = 1'b0;
    endtask

    function automatic logic [31:0] gen_addr();
        int r = $urandom_range(0, 9);
        if (r == 0) return 32'(BASE - 4 * $urandom_range(1, 8));
        if (r == 1) return 32'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 8));
        return 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(0, 3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, bad;
        for (int i = 0; i < DEPTH; i++) init_val[i] = $urandom;
        init_val[0] = 32'h5;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val[i];
        idle_in();
        wb_en1 = 0; rd1 = 0; wr1 = 0; alu1 = 0; rm1 = 0; dest1 = 0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ctl", {wb_wb_en, wb_mem_r_en, addr_err, mem_re, mem_we, freeze, wb_dest}, 0);
        chk("rst_data", {wb_alu_res, wb_mem_data}, 0);
        chk("rst_ctl_w1", {wb_wb_en1, wb_mem_r_en1, addr_err1, mem_re1, mem_we1, freeze1, wb_dest1}, 0);
        repeat (2) @(negedge clk);
        preload = 1'b0;
        rst = 1'b1;

        // single-cycle array: load word 0, then a store
        @(negedge clk); rd1 = 1; alu1 = 32'd1024; wb_en1 = 1; dest1 = 5;
        #3 chk("w1_freeze_req", freeze1, 1);
        @(negedge clk); #3;
        chk("w1_access", {freeze1, mem_re1}, 2'b01);
        @(negedge clk); rd1 = 0; alu1 = 0; wb_en1 = 0; dest1 = 0; #3;
        chk("w1_load_ctl", {wb_wb_en1, wb_mem_r_en1, wb_dest1, wb_alu_res1}, {1'b1, 1'b1, 4'd5, 32'd1024});
        chk("w1_load_data", wb_mem_data1, 32'h5);
        @(negedge clk); wr1 = 1; alu1 = 32'd1028; rm1 = 32'h77; #3;
        chk("w1_store_freeze", freeze1, 1);
        @(negedge clk); #3;
        chk("w1_store_we", {freeze1, mem_we1, mem_addr1, mem_wdata1}, {1'b0, 1'b1, 6'd1, 32'h77});
        @(negedge clk); wr1 = 0; alu1 = 0; rm1 = 0; #3;
        chk("w1_array", arr1[1], 32'h77);

        mon_on();
        issue(0, 0, 1, 32'h2A, 32'd0, 4'd3);
        issue(0, 1, 0, 32'd1028, 32'hDEADBEEF, 4'd0);
        issue(1, 0, 1, 32'd1028, 32'd0, 4'd7);
        issue(1, 0, 1, 32'd1020, 32'd0, 4'd8);
        issue(0, 1, 0, 32'd1280, 32'h55, 4'd0);
        issue(1, 1, 1, 32'd1032, 32'hCAFEF00D, 4'd9);
        issue(1, 0, 1, 32'd1032, 32'd0, 4'd4);
        issue(0, 0, 1, $urandom, 32'd0, 4'd2);
        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4) issue(0, 0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            else if (k < 7) issue(1, 0, 1'($urandom_range(0, 1)), gen_addr(), $urandom, 4'($urandom_range(0, 15)));
            else if (k < 9) issue(0, 1, 1'($urandom_range(0, 1)), gen_addr(), $urandom, 4'($urandom_range(0, 15)));
            else issue(1, 1, 1'($urandom_range(0, 1)), gen_addr(), $urandom, 4'($urandom_range(0, 15)));
        end
        mon_off();

        // reset while cnt = 1 during a store to word 3
        @(negedge clk); mem_write = 1; alu_res = 32'd1036; val_rm = 32'h12345678;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0; idle_in();
        #1;
        chk("midrst_ctl", {wb_wb_en, wb_mem_r_en, addr_err, mem_re, mem_we, freeze, wb_dest}, 0);
        chk("midrst_data", {wb_alu_res, wb_mem_data}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        last_md = 32'd0; md_known = 1'b1;
        chk("midrst_array", arr[3], ref_mem[3]);

        mon_on();
        issue(0, 0, 1, 32'h2A, 32'd0, 4'd3);
        issue(1, 0, 1, 32'd1036, 32'd0, 4'd6);
        issue(0, 0, 1, 32'h1, 32'd0, 4'd1);
        mon_off();

        chk("queue_empty", q.size(), 0);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (arr[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
